// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle ALU.
// One command is in flight at a time. A result timeout returns an error response.
module alu_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int FUN_WIDTH  = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ0_VALID,
  input  logic [FUN_WIDTH-1:0]    REQ0_FUN,
  input  logic [DATA_WIDTH-1:0]   REQ0_A,
  input  logic [DATA_WIDTH-1:0]   REQ0_B,
  output logic                    REQ0_READY,
  input  logic                    REQ1_VALID,
  input  logic [FUN_WIDTH-1:0]    REQ1_FUN,
  input  logic [DATA_WIDTH-1:0]   REQ1_A,
  input  logic [DATA_WIDTH-1:0]   REQ1_B,
  output logic                    REQ1_READY,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic [DATA_WIDTH-1:0]   ALU_A,
  output logic [DATA_WIDTH-1:0]   ALU_B,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VALID,
  output logic                    RSP_VALID,
  output logic                    RSP_ID,
  output logic [2*DATA_WIDTH-1:0] RSP_DATA,
  output logic                    RSP_ERR,
  input  logic                    RSP_READY
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e                  state_q, state_d;
  logic                    pri_q, pri_d;
  logic                    id_q, id_d;
  logic [FUN_WIDTH-1:0]    fun_q, fun_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [7:0]              timer_q, timer_d;
  logic                    hit_q, hit_d;
  logic [2*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;

  logic gnt_any;
  logic gnt_id;

  assign gnt_any = REQ0_VALID | REQ1_VALID;
  assign gnt_id  = (REQ0_VALID & REQ1_VALID) ? pri_q : REQ1_VALID;

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking so every flop samples pre-edge values together.
    if (!RST) begin
      state_q    <= S_IDLE;
      pri_q      <= 1'b0;
      id_q       <= 1'b0;
      fun_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      timer_q    <= '0;
      hit_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pri_q      <= pri_d;
      id_q       <= id_d;
      fun_q      <= fun_d;
      a_q        <= a_d;
      b_q        <= b_d;
      timer_q    <= timer_d;
      hit_q      <= hit_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first, so no path leaves a _d unassigned (no latches).
    state_d    = state_q;
    pri_d      = pri_q;
    id_d       = id_q;
    fun_d      = fun_q;
    a_d        = a_q;
    b_d        = b_q;
    timer_d    = timer_q;
    hit_d      = hit_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          id_d    = gnt_id;
          pri_d   = ~gnt_id;
          fun_d   = gnt_id ? REQ1_FUN : REQ0_FUN;
          a_d     = gnt_id ? REQ1_A   : REQ0_A;
          b_d     = gnt_id ? REQ1_B   : REQ0_B;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        hit_d   = 1'b0;
        // A result arriving with the issue strobe is kept and answered from WAIT.
        if (ALU_OUT_VALID) begin
          rsp_data_d = ALU_OUT;
          rsp_err_d  = 1'b0;
          hit_d      = 1'b1;
        end
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ALU_OUT_VALID) begin
          rsp_data_d = ALU_OUT;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (hit_q) begin
          state_d = S_RESP;
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_RESP: begin
        if (RSP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    REQ0_READY = RST && (state_q == S_IDLE) && gnt_any && !gnt_id;
    REQ1_READY = RST && (state_q == S_IDLE) && gnt_any && gnt_id;
    ALU_EN     = RST && (state_q == S_ISSUE);
    RSP_VALID  = RST && (state_q == S_RESP);
    ALU_FUN    = fun_q;
    ALU_A      = a_q;
    ALU_B      = b_q;
    RSP_ID     = id_q;
    RSP_DATA   = rsp_data_q;
    RSP_ERR    = rsp_err_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: reset, directed vector table, reset-in-WAIT flush, and
// randomized transactions checked against a transaction-level arbitration/ALU model.
module tb_alu_arbiter;
  localparam int DW = 8;
  localparam int FW = 4;
  localparam int TO = 15;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
  logic [FW-1:0] REQ0_FUN = '0, REQ1_FUN = '0;
  logic [DW-1:0] REQ0_A = '0, REQ0_B = '0, REQ1_A = '0, REQ1_B = '0;
  logic          REQ0_READY, REQ1_READY;
  logic          ALU_EN;
  logic [FW-1:0] ALU_FUN;
  logic [DW-1:0] ALU_A, ALU_B;
  logic [2*DW-1:0] ALU_OUT;
  logic          ALU_OUT_VALID;
  logic          RSP_VALID, RSP_ID, RSP_ERR;
  logic [2*DW-1:0] RSP_DATA;
  logic          RSP_READY = 1'b0;

  logic          alu_vld_m = 1'b0;
  logic          alu_vld_f = 1'b0;
  logic [15:0]   alu_out_m = '0;
  int            alu_delay = 1;
  int            alu_cnt = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  logic          pri_m = 1'b0;

  assign ALU_OUT_VALID = alu_vld_m | alu_vld_f;
  assign ALU_OUT       = alu_vld_f ? 16'hdead : alu_out_m;

  alu_arbiter #(.DATA_WIDTH(DW), .FUN_WIDTH(FW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_FUN(REQ0_FUN), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B),
    .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_FUN(REQ1_FUN), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
    .REQ1_READY(REQ1_READY),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
    .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .RSP_READY(RSP_READY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        v0, v1;
    logic [3:0]  f0;
    logic [7:0]  a0, b0;
    logic [3:0]  f1;
    logic [7:0]  a1, b1;
    int          delay;     // WAIT cycle carrying the result; 0 = ALU never answers
    int          stall;     // extra RESP cycles with RSP_READY low
    logic        exp_id;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_lat;   // cycles from grant to first RSP_VALID
  } vec_t;

  function automatic logic [15:0] alu_f(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'h2:    return 16'(a) + 16'(b);
      4'h3:    return 16'(a) * 16'(b);
      4'h5:    return 16'(a) - 16'(b);
      default: return {a, b};
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ALU model: answers `alu_delay` cycles after the issue strobe, from the operands it was given.
  always @(posedge CLK) begin
    #2;
    alu_vld_m = 1'b0;
    if (alu_cnt > 0) begin
      alu_cnt--;
      if (alu_cnt == 0) alu_vld_m = 1'b1;
    end
    if (ALU_EN === 1'b1) begin
      alu_cnt   = alu_delay;
      alu_out_m = alu_f(ALU_FUN, ALU_A, ALU_B);
    end
  end

  // Starts at posedge+1 of an IDLE cycle, returns at posedge+1 of the IDLE cycle after the handshake.
  task automatic run_txn(input vec_t v);
    logic [3:0] f;
    logic [7:0] a, b;
    bit ok;
    int lat;
    f = v.exp_id ? v.f1 : v.f0;
    a = v.exp_id ? v.a1 : v.a0;
    b = v.exp_id ? v.b1 : v.b0;
    REQ0_VALID = v.v0; REQ0_FUN = v.f0; REQ0_A = v.a0; REQ0_B = v.b0;
    REQ1_VALID = v.v1; REQ1_FUN = v.f1; REQ1_A = v.a1; REQ1_B = v.b1;
    RSP_READY = 1'b0;
    alu_delay = v.delay;
    @(negedge CLK);
    check("grant_ready", {RSP_VALID, ALU_EN, REQ1_READY, REQ0_READY},
          {1'b0, 1'b0, v.exp_id, ~v.exp_id});
    @(posedge CLK); #1;
    if (v.exp_id) REQ1_VALID = 1'b0; else REQ0_VALID = 1'b0;
    @(negedge CLK);
    check("issue", {ALU_EN, REQ1_READY, REQ0_READY, ALU_FUN, ALU_A, ALU_B},
          {3'b100, f, a, b});
    ok = 1'b1;
    lat = 1;
    while (RSP_VALID !== 1'b1 && lat < TO + 5) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      lat++;
      if ({ALU_EN, REQ1_READY, REQ0_READY, ALU_FUN, ALU_A, ALU_B} !== {3'b000, f, a, b}) ok = 1'b0;
    end
    check("wait_quiet", 64'(ok), 64'd1);
    check("latency", 64'(lat), 64'(v.exp_lat));
    check("rsp", {RSP_VALID, RSP_ID, RSP_ERR, RSP_DATA}, {1'b1, v.exp_id, v.exp_err, v.exp_data});
    ok = 1'b1;
    for (int s = 0; s < v.stall; s++) begin
      @(posedge CLK); #1;
      alu_vld_f = 1'b1;
      @(negedge CLK);
      if ({RSP_VALID, RSP_ID, RSP_ERR, RSP_DATA, ALU_EN, REQ1_READY, REQ0_READY} !==
          {1'b1, v.exp_id, v.exp_err, v.exp_data, 3'b000}) ok = 1'b0;
    end
    if (v.stall > 0) check("resp_hold", 64'(ok), 64'd1);
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    alu_vld_f = 1'b0;
    RSP_READY = 1'b0;
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    pri_m = ~v.exp_id;
  endtask

  vec_t tbl[8];
  vec_t v;
  bit   ok;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 4'h3, 8'h12, 8'h10, 4'h2, 8'hff, 8'h02, 1,  0, 1'b0, 16'h0120, 1'b0, 3};
    tbl[1] = '{1'b1, 1'b1, 4'h2, 8'h01, 8'h01, 4'h2, 8'hff, 8'h02, 2,  0, 1'b1, 16'h0101, 1'b0, 4};
    tbl[2] = '{1'b1, 1'b1, 4'h5, 8'h03, 8'h05, 4'h3, 8'h02, 8'h02, 1,  0, 1'b0, 16'hfffe, 1'b0, 3};
    tbl[3] = '{1'b1, 1'b1, 4'h2, 8'h01, 8'h02, 4'h7, 8'hab, 8'hcd, 15, 5, 1'b1, 16'habcd, 1'b0, 17};
    tbl[4] = '{1'b0, 1'b1, 4'h0, 8'h00, 8'h00, 4'h2, 8'h01, 8'h01, 0,  0, 1'b1, 16'h0000, 1'b1, 17};
    tbl[5] = '{1'b1, 1'b1, 4'h3, 8'hff, 8'hff, 4'h2, 8'h04, 8'h04, 16, 1, 1'b0, 16'h0000, 1'b1, 17};
    tbl[6] = '{1'b1, 1'b0, 4'h4, 8'h11, 8'h22, 4'h2, 8'h00, 8'h00, 3,  0, 1'b0, 16'h1122, 1'b0, 5};
    tbl[7] = '{1'b1, 1'b1, 4'h2, 8'h09, 8'h09, 4'h2, 8'h80, 8'h80, 1,  2, 1'b1, 16'h0100, 1'b0, 3};

    // Reset held two cycles with a pending request: everything stays quiet.
    RST = 1'b0;
    REQ0_VALID = 1'b1; REQ0_FUN = 4'h2; REQ0_A = 8'h05; REQ0_B = 8'h03;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      check("reset_outputs",
            {REQ0_READY, REQ1_READY, ALU_EN, ALU_FUN, ALU_A, ALU_B, RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR},
            64'd0);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    REQ0_VALID = 1'b0;
    pri_m = 1'b0;

    // Basic single transaction: 5 + 3 answered one cycle after the strobe.
    v = '{1'b1, 1'b0, 4'h2, 8'h05, 8'h03, 4'h0, 8'h00, 8'h00, 1, 0, 1'b0, 16'h0008, 1'b0, 3};
    run_txn(v);

    // Reset during WAIT: command dropped, late ALU result ignored, priority back to 0.
    REQ0_VALID = 1'b1; REQ0_FUN = 4'h3; REQ0_A = 8'h07; REQ0_B = 8'h09;
    alu_delay = 4;
    @(posedge CLK); #1;
    REQ0_VALID = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("rst_in_wait_gated", {REQ0_READY, REQ1_READY, ALU_EN, RSP_VALID}, 64'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    check("rst_in_wait_cleared",
          {REQ0_READY, REQ1_READY, ALU_EN, ALU_FUN, ALU_A, ALU_B, RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR},
          64'd0);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      if ({RSP_VALID, ALU_EN, REQ0_READY, REQ1_READY} !== 4'b0000) ok = 1'b0;
    end
    check("rst_flush_quiet", 64'(ok), 64'd1);
    @(posedge CLK); #1;
    pri_m = 1'b0;

    // Directed table, starting from priority 0.
    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // Randomized transactions against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      v.v0 = 1'($urandom_range(0, 1));
      v.v1 = v.v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      v.f0 = 4'($urandom); v.a0 = 8'($urandom); v.b0 = 8'($urandom);
      v.f1 = 4'($urandom); v.a1 = 8'($urandom); v.b1 = 8'($urandom);
      v.delay = $urandom_range(0, TO + 2);
      v.stall = $urandom_range(0, 2);
      v.exp_id = (v.v0 && v.v1) ? pri_m : v.v1;
      if (v.delay >= 1 && v.delay <= TO) begin
        v.exp_data = v.exp_id ? alu_f(v.f1, v.a1, v.b1) : alu_f(v.f0, v.a0, v.b0);
        v.exp_err  = 1'b0;
        v.exp_lat  = v.delay + 2;
      end else begin
        v.exp_data = 16'h0000;
        v.exp_err  = 1'b1;
        v.exp_lat  = TO + 2;
      end
      run_txn(v);
    end

    @(negedge CLK);
    check("final_idle", {RSP_VALID, ALU_EN, REQ0_READY, REQ1_READY}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
